// File: rtl/life_gen_sequencer_if.sv
// rtl/life_gen_sequencer_if.sv - generation request handshake between sequencer and Life engine
//
// Purpose: bundles the request/result handshake between the run/step sequencer
// and the Life engine datapath.
// Signals:
//   eng_req   sequencer -> engine  generation request, held until eng_ack
//   eng_grid  sequencer -> engine  grid the engine computes the next generation from
//   eng_ack   engine -> sequencer  one-cycle pulse, eng_next valid
//   eng_next  engine -> sequencer  next generation
// Modports: master = sequencer side, slave = engine side.

interface life_gen_sequencer_if #(
  parameter int GRID_W = 256
);
  logic              eng_req;
  logic [GRID_W-1:0] eng_grid;
  logic              eng_ack;
  logic [GRID_W-1:0] eng_next;

  modport master (
    output eng_req,
    output eng_grid,
    input  eng_ack,
    input  eng_next
  );

  modport slave (
    input  eng_req,
    input  eng_grid,
    output eng_ack,
    output eng_next
  );
endinterface

// File: rtl/life_gen_sequencer.sv
// rtl/life_gen_sequencer.sv - run/step controller owning the 16x16 Life grid register
//
// Purpose: holds the current generation, loads it from the seed, paces
// generation requests to the engine from a programmable tick (free-run) or from
// single-step edges, and halts on still-life or extinction.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high
//   on_i         1 = free-run at tick rate, 0 = paused / single-step
//   step_i       single-step request level; only its rising edge acts
//   load_i       load seed_i into the grid; wins over everything else
//   seed_i       initial pattern, row r = bits[16r+15:16r]
//   tick_div_i   WAIT cycles before a free-run request; 0 behaves as 1
//   eng          engine handshake (master side): eng_req, eng_grid, eng_ack, eng_next
//   display_o    current generation
//   gen_count_o  generations since last load, saturating
//   running_o    in WAIT with on_i=1, or in REQ
//   stable_o     last generation equalled its predecessor
//   extinct_o    current grid is all zero

module life_gen_sequencer #(
  parameter int GRID_W = 256,
  parameter int DIV_W  = 24,
  parameter int GEN_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                on_i,
  input  logic                step_i,
  input  logic                load_i,
  input  logic [GRID_W-1:0]   seed_i,
  input  logic [DIV_W-1:0]    tick_div_i,
  life_gen_sequencer_if.master eng,
  output logic [GRID_W-1:0]   display_o,
  output logic [GEN_W-1:0]    gen_count_o,
  output logic                running_o,
  output logic                stable_o,
  output logic                extinct_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_REQ,
    S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [GRID_W-1:0]   display_q, display_d;
  logic [GEN_W-1:0]    gen_q, gen_d;
  logic [DIV_W-1:0]    tick_q, tick_d;
  logic                stable_q, stable_d;
  logic                extinct_q, extinct_d;
  logic                req_q, req_d;
  logic                step_q;

  logic [DIV_W-1:0]    tick_last;
  logic                step_rise;
  logic                ack_take;
  logic [GEN_W-1:0]    gen_inc;
  logic                next_same;
  logic                next_zero;

  // Terminal count of the WAIT counter; a divider of 0 behaves like 1.
  assign tick_last = (tick_div_i == '0) ? '0 : tick_div_i - DIV_W'(1);

  assign step_rise = step_i & ~step_q;

  // A load in the same cycle as the ack discards the result: the seed wins.
  assign ack_take  = (state_q == S_REQ) && eng.eng_ack && !load_i;

  assign gen_inc   = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + GEN_W'(1);
  assign next_same = (eng.eng_next == display_q);
  assign next_zero = (eng.eng_next == '0);

  always_comb begin
    state_d   = state_q;
    display_d = display_q;
    gen_d     = gen_q;
    tick_d    = tick_q;
    stable_d  = stable_q;
    extinct_d = extinct_q;

    case (state_q)
      S_IDLE: begin
      end

      S_LOAD: begin
        display_d = seed_i;
        gen_d     = '0;
        stable_d  = 1'b0;
        tick_d    = '0;
        extinct_d = (seed_i == '0);
        state_d   = (seed_i == '0) ? S_HALT : S_WAIT;
      end

      S_WAIT: begin
        if (on_i) begin
          if (tick_q >= tick_last) begin
            tick_d  = '0;
            state_d = S_REQ;
          end else begin
            tick_d  = tick_q + DIV_W'(1);
          end
        end else if (step_rise) begin
          // Paused count is left as is so free-running resumes where it stopped.
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (ack_take) begin
          display_d = eng.eng_next;
          gen_d     = gen_inc;
          stable_d  = next_same;
          extinct_d = next_zero;
          state_d   = (next_same || next_zero) ? S_HALT : S_WAIT;
        end
      end

      S_HALT: begin
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_i) begin
      state_d = S_LOAD;
    end

    // Request is registered: it is high exactly while the FSM sits in REQ.
    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      display_q <= '0;
      gen_q     <= '0;
      tick_q    <= '0;
      stable_q  <= 1'b0;
      extinct_q <= 1'b0;
      req_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      display_q <= display_d;
      gen_q     <= gen_d;
      tick_q    <= tick_d;
      stable_q  <= stable_d;
      extinct_q <= extinct_d;
      req_q     <= req_d;
      step_q    <= step_i;
    end
  end

  assign eng.eng_req  = req_q;
  assign eng.eng_grid = display_q;
  assign display_o    = display_q;
  assign gen_count_o  = gen_q;
  assign stable_o     = stable_q;
  assign extinct_o    = extinct_q;
  assign running_o    = ((state_q == S_WAIT) && on_i) || (state_q == S_REQ);

endmodule

// File: tb/tb_life_gen_sequencer.sv
// tb/tb_life_gen_sequencer.sv - self-checking bench for life_gen_sequencer
//
// Purpose: scenario table, directed multi-cycle sequences and randomized
// stimulus, all compared every cycle against a cycle-level reference model.
// The second instance uses a 3-bit generation counter so saturation is reachable.

module tb_life_gen_sequencer;
  localparam int GW = 256;
  localparam int DW = 24;
  localparam int NW = 16;
  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_REQ  = 3;
  localparam int PH_HALT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic on, step, load;
  logic [GW-1:0] seed;
  logic [DW-1:0] tick_div;
  logic [GW-1:0] display;
  logic [NW-1:0] gen_count;
  logic running, stable, extinct;

  logic on2, step2, load2;
  logic [GW-1:0] seed2;
  logic [DW-1:0] div2;
  logic [GW-1:0] display2;
  logic [2:0] gen2;
  logic running2, stable2, extinct2;

  life_gen_sequencer_if #(.GRID_W(GW)) bus ();
  life_gen_sequencer_if #(.GRID_W(GW)) bus2 ();

  life_gen_sequencer #(.GRID_W(GW), .DIV_W(DW), .GEN_W(NW)) dut (
    .clk(clk), .reset(reset), .on_i(on), .step_i(step), .load_i(load),
    .seed_i(seed), .tick_div_i(tick_div), .eng(bus),
    .display_o(display), .gen_count_o(gen_count), .running_o(running),
    .stable_o(stable), .extinct_o(extinct)
  );

  life_gen_sequencer #(.GRID_W(GW), .DIV_W(DW), .GEN_W(3)) dut_sat (
    .clk(clk), .reset(reset), .on_i(on2), .step_i(step2), .load_i(load2),
    .seed_i(seed2), .tick_div_i(div2), .eng(bus2),
    .display_o(display2), .gen_count_o(gen2), .running_o(running2),
    .stable_o(stable2), .extinct_o(extinct2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int            m_ph;
  logic [GW-1:0] m_disp;
  int            m_gen;
  int            m_tick;
  bit            m_stable, m_ext, m_stepq;

  int  req_cnt, req_cnt2, lat;
  bit  eng_auto, eng_life, spurious;
  int  req_rises, cyc_n;
  bit  prev_req;
  int  rise_log[$];

  logic [GW-1:0] bv, bh, blk, one;

  typedef struct {
    logic [GW-1:0] seed;
    int            div;
    int            lat;
    int            n;
    int            exp_gen;
    int            exp_req;
    logic [GW-1:0] exp_disp;
    bit            exp_stable;
    bit            exp_ext;
  } scen_t;
  scen_t tab[7];

  task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [GW-1:0] rand256();
    logic [GW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Conway rule on a bounded 16x16 board (cells outside are dead).
  function automatic logic [GW-1:0] life_next(input logic [GW-1:0] g);
    logic [GW-1:0] n;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int cnt;
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 16 &&
                c + dc >= 0 && c + dc < 16)
              if (g[(r + dr) * 16 + c + dc]) cnt++;
        n[r * 16 + c] = (cnt == 3) || (g[r * 16 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_disp = '0; m_gen = 0; m_tick = 0;
    m_stable = 0; m_ext = 0; m_stepq = 0;
  endtask

  // Advance the reference by one clock using the inputs presented this cycle.
  task automatic model_clock();
    int  nph, dv;
    bit  rise;
    if (reset) begin
      model_reset();
      return;
    end
    dv = (tick_div == '0) ? 1 : int'(tick_div);
    rise = step && !m_stepq;
    m_stepq = step;
    nph = m_ph;
    if (m_ph == PH_LOAD) begin
      m_disp = seed; m_gen = 0; m_stable = 0; m_tick = 0; m_ext = (seed == '0);
      nph = (seed == '0) ? PH_HALT : PH_WAIT;
    end else if (m_ph == PH_WAIT) begin
      if (on) begin
        if (m_tick + 1 >= dv) begin m_tick = 0; nph = PH_REQ; end
        else m_tick++;
      end else if (rise) nph = PH_REQ;
    end else if (m_ph == PH_REQ && bus.eng_ack && !load) begin
      m_stable = (bus.eng_next == m_disp);
      m_ext = (bus.eng_next == '0);
      m_disp = bus.eng_next;
      if (m_gen < 65535) m_gen++;
      nph = (m_stable || m_ext) ? PH_HALT : PH_WAIT;
    end
    if (load) nph = PH_LOAD;
    m_ph = nph;
  endtask

  task automatic compare_all();
    chk("display", display, m_disp);
    chk("eng_grid", bus.eng_grid, m_disp);
    chk("gen_count", GW'(gen_count), GW'(m_gen));
    chk("eng_req", GW'(bus.eng_req), GW'(m_ph == PH_REQ));
    chk("stable", GW'(stable), GW'(m_stable));
    chk("extinct", GW'(extinct), GW'(m_ext));
    chk("running", GW'(running), GW'((m_ph == PH_WAIT && on) || m_ph == PH_REQ));
  endtask

  // Engine acks lat cycles after it first sees eng_req on a clock edge.
  task automatic engine_drive();
    if (!eng_auto) return;
    if (bus.eng_req) req_cnt++; else req_cnt = 0;
    bus.eng_ack = 1'b0;
    bus.eng_next = rand256();
    if (bus.eng_req && req_cnt == lat + 1) begin
      bus.eng_ack = 1'b1;
      if (eng_life) bus.eng_next = life_next(bus.eng_grid);
      else case ($urandom_range(0, 3))
        0: bus.eng_next = bus.eng_grid;
        1: bus.eng_next = '0;
        default: ;
      endcase
    end else if (spurious && !bus.eng_req && $urandom_range(0, 7) == 0) begin
      bus.eng_ack = 1'b1;
    end
  endtask

  task automatic engine2_drive();
    if (bus2.eng_req) req_cnt2++; else req_cnt2 = 0;
    bus2.eng_ack = bus2.eng_req && req_cnt2 == 2;
    bus2.eng_next = (bus2.eng_grid == bv) ? bh : bv;
  endtask

  task automatic cyc();
    model_clock();
    @(posedge clk);
    #1;
    cyc_n++;
    compare_all();
    if (bus.eng_req && !prev_req) begin
      req_rises++;
      rise_log.push_back(cyc_n);
    end
    prev_req = bus.eng_req;
    engine_drive();
    engine2_drive();
  endtask

  task automatic do_load(input logic [GW-1:0] s);
    seed = s; load = 1'b1; cyc(); load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [GW-1:0] old;
    bit found;
    int gap;
    int divs[3];
    int gaps[3];
    divs = '{3, 0, 1};
    gaps = '{5, 3, 3};

    on = 0; step = 0; load = 0; seed = '0; tick_div = '0;
    on2 = 1; step2 = 0; load2 = 0; div2 = DW'(1);
    bus.eng_ack = 0; bus.eng_next = '0; bus2.eng_ack = 0; bus2.eng_next = '0;
    bv = '0; bv[7*16+7] = 1; bv[8*16+7] = 1; bv[9*16+7] = 1;
    bh = '0; bh[8*16+6] = 1; bh[8*16+7] = 1; bh[8*16+8] = 1;
    blk = '0; blk[4*16+4] = 1; blk[4*16+5] = 1; blk[5*16+4] = 1; blk[5*16+5] = 1;
    one = '0; one[3*16+9] = 1;
    seed2 = bv;

    //           seed div lat  n gen req disp stable ext
    tab[0] = '{bv,   3, 1, 22, 4, 4, bv,  1'b0, 1'b0};
    tab[1] = '{blk,  2, 1, 20, 1, 1, blk, 1'b1, 1'b0};
    tab[2] = '{'0,   1, 1, 10, 0, 0, '0,  1'b0, 1'b1};
    tab[3] = '{bv,   0, 1, 10, 3, 3, bh,  1'b0, 1'b0};
    tab[4] = '{one,  1, 2, 20, 1, 1, '0,  1'b0, 1'b1};
    tab[5] = '{bv,   1, 1, 10, 3, 3, bh,  1'b0, 1'b0};
    tab[6] = '{bv,   5, 3, 33, 3, 4, bh,  1'b0, 1'b0};

    eng_auto = 1; eng_life = 1; spurious = 0; lat = 1;
    req_cnt = 0; req_cnt2 = 0; req_rises = 0; cyc_n = 0; prev_req = 0;
    model_reset();
    #1 reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // Scenario table: free-running with a Life engine.
    for (int i = 0; i < 7; i++) begin
      tick_div = DW'(tab[i].div); lat = tab[i].lat; on = 1; step = 0;
      do_load(tab[i].seed);
      req_rises = 0;
      repeat (tab[i].n) cyc();
      chk($sformatf("sc%0d gen", i), GW'(gen_count), GW'(tab[i].exp_gen));
      chk($sformatf("sc%0d reqs", i), GW'(req_rises), GW'(tab[i].exp_req));
      chk($sformatf("sc%0d disp", i), display, tab[i].exp_disp);
      chk($sformatf("sc%0d stable", i), GW'(stable), GW'(tab[i].exp_stable));
      chk($sformatf("sc%0d extinct", i), GW'(extinct), GW'(tab[i].exp_ext));
    end

    // Request spacing for tick_div 3, 0, 1.
    for (int k = 0; k < 3; k++) begin
      tick_div = DW'(divs[k]); lat = 1; on = 1;
      do_load(bv);
      rise_log.delete();
      repeat (30) cyc();
      gap = (rise_log.size() >= 3) ? rise_log[2] - rise_log[1] : -1;
      chk($sformatf("gap div%0d", divs[k]), GW'(gap), GW'(gaps[k]));
    end

    // Single step: three pulses, then one long hold.
    on = 0; tick_div = DW'(3); lat = 1; step = 0;
    do_load(bv);
    repeat (4) cyc();
    req_rises = 0;
    for (int k = 0; k < 3; k++) begin
      step = 1; cyc(); step = 0;
      repeat (6) cyc();
    end
    chk("step3 reqs", GW'(req_rises), GW'(3));
    chk("step3 gen", GW'(gen_count), GW'(3));
    chk("step3 disp", display, bh);
    step = 1; repeat (10) cyc(); step = 0;
    repeat (5) cyc();
    chk("hold reqs", GW'(req_rises), GW'(4));
    chk("hold gen", GW'(gen_count), GW'(4));

    // Load in REQ coincident with an ack.
    on = 1; tick_div = DW'(2); lat = 1;
    do_load(bv);
    found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      cyc();
      if (bus.eng_req && gen_count == 1) found = 1;
    end
    chk("ldreq reached", GW'(found), GW'(1));
    eng_auto = 0;
    old = display;
    bus.eng_ack = 1; bus.eng_next = rand256();
    do_load(blk);
    chk("ldreq disp kept", display, old);
    chk("ldreq req off", GW'(bus.eng_req), GW'(0));
    chk("ldreq gen kept", GW'(gen_count), GW'(1));
    bus.eng_ack = 0;
    cyc();
    chk("ldreq disp seed", display, blk);
    chk("ldreq gen clr", GW'(gen_count), GW'(0));
    eng_auto = 1; req_cnt = 0;

    // Asynchronous reset while a request is outstanding.
    tick_div = DW'(3);
    do_load(bv);
    found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      cyc();
      if (bus.eng_req) found = 1;
    end
    chk("rst reached req", GW'(found), GW'(1));
    #2;
    reset = 1'b1;
    bus.eng_ack = 0;
    #1;
    chk("rst display", display, '0);
    chk("rst eng_grid", bus.eng_grid, '0);
    chk("rst gen", GW'(gen_count), '0);
    chk("rst eng_req", GW'(bus.eng_req), '0);
    chk("rst stable", GW'(stable), '0);
    chk("rst extinct", GW'(extinct), '0);
    chk("rst running", GW'(running), '0);
    model_reset();
    req_cnt = 0; prev_req = 0;
    cyc();
    reset = 1'b0;
    repeat (3) cyc();

    // Randomized run against the reference model.
    eng_life = 0; spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 29) == 0);
      if (load) begin
        seed = ($urandom_range(0, 5) == 0) ? '0 : rand256();
        tick_div = DW'($urandom_range(0, 4));
        lat = $urandom_range(1, 3);
      end
      if ($urandom_range(0, 15) == 0) on = ~on;
      if ($urandom_range(0, 3) == 0) step = ~step;
      cyc();
    end
    load = 0;
    repeat (2) cyc();

    // Saturation on the narrow-counter instance.
    load2 = 1; cyc(); load2 = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if (i == 19) begin
        chk("sat gen6", GW'(gen2), GW'(6));
        chk("sat disp6", display2, bv);
      end
      if (i == 22) begin
        chk("sat gen7", GW'(gen2), GW'(7));
        chk("sat disp7", display2, bh);
      end
      if (i == 25) begin
        chk("sat hold", GW'(gen2), GW'(7));
        chk("sat disp8", display2, bv);
      end
      if (i == 60) chk("sat end", GW'(gen2), GW'(7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
